// File: rtl/cavlc_bitstream_shifter.sv
// CAVLC bitstream front end: buffers up to 64 stream bits MSB-aligned and exposes a 16-bit
// lookahead window; bits are consumed by the control FSM and refilled one 32-bit word at a time.
module cavlc_bitstream_shifter (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Enable,
  input  logic        Flush,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  input  logic        ShiftEn,
  input  logic [4:0]  NumShift,
  output logic [15:0] Window,
  output logic        BarrelShifterReady,
  output logic [6:0]  BitCount,
  output logic        ShiftError
);

  logic [63:0] buf_q, buf_d, base_buf;
  logic [6:0]  cnt_q, cnt_d, base_cnt, shamt;
  logic        err_q, err_d, acc;

  assign shamt   = ShiftEn ? {2'b00, NumShift} : 7'd0;
  // Accept only while the incoming word is guaranteed to fit in 64 bits.
  assign InReady = Enable && !Flush && (cnt_q <= 7'd32);
  assign acc     = InValid && InReady;

  assign Window             = buf_q[63:48];
  assign BitCount           = cnt_q;
  assign BarrelShifterReady = (cnt_q >= 7'd32);
  assign ShiftError         = err_q;

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    base_buf = '0;
    base_cnt = '0;
    if (Flush) begin
      buf_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (Enable) begin
      if (shamt > cnt_q) begin
        // Over-consumption: drop everything and flag it; a same-cycle word still lands.
        err_d = 1'b1;
      end else begin
        base_buf = buf_q << shamt;
        base_cnt = cnt_q - shamt;
      end
      buf_d = base_buf;
      cnt_d = base_cnt;
      if (acc) begin
        buf_d = base_buf | ({InData, 32'h0} >> base_cnt);
        cnt_d = base_cnt + 7'd32;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      buf_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
// Scoreboard bench for cavlc_bitstream_shifter: the driver queues the state expected after each
// edge, and a separate monitor compares it against the DUT shortly after that edge.
module tb_cavlc_bitstream_shifter;

  logic        Clk, nReset, Enable, Flush, InValid, InReady, ShiftEn;
  logic [31:0] InData;
  logic [4:0]  NumShift;
  logic [15:0] Window;
  logic        BarrelShifterReady, ShiftError;
  logic [6:0]  BitCount;

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] win;
    logic [6:0]  cnt;
    logic        err;
    logic        ir;
  } exp_t;

  exp_t sb_q[$];
  exp_t rst_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   step_id = 0;

  cavlc_bitstream_shifter dut (
    .Clk               (Clk),
    .nReset            (nReset),
    .Enable            (Enable),
    .Flush             (Flush),
    .InData            (InData),
    .InValid           (InValid),
    .InReady           (InReady),
    .ShiftEn           (ShiftEn),
    .NumShift          (NumShift),
    .Window            (Window),
    .BarrelShifterReady(BarrelShifterReady),
    .BitCount          (BitCount),
    .ShiftError        (ShiftError)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic cmp(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("Window", e.id, {16'h0, Window}, {16'h0, e.win});
    cmp("BitCount", e.id, {25'h0, BitCount}, {25'h0, e.cnt});
    cmp("BarrelShifterReady", e.id, {31'h0, BarrelShifterReady}, {31'h0, (e.cnt >= 7'd32)});
    cmp("ShiftError", e.id, {31'h0, ShiftError}, {31'h0, e.err});
    cmp("InReady", e.id, {31'h0, InReady}, {31'h0, e.ir});
  endtask

  // Monitor: compares every expectation tagged for the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc = cyc + 1;
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL missed (step %0d): tagged cycle %0d, now %0d", e.id, e.cyc, cyc);
        end else begin
          check_all(e);
        end
      end
    end
  end

  // Reset monitor: asynchronous reset must clear outputs without a clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge nReset);
      #1;
      if (rst_q.size() > 0) begin
        e = rst_q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input logic en, input logic fl, input logic se, input logic [4:0] ns,
                      input logic iv, input logic [31:0] d, input logic [15:0] w,
                      input logic [6:0] c, input logic e, input logic ir);
    @(negedge Clk);
    Enable   = en;
    Flush    = fl;
    ShiftEn  = se;
    NumShift = ns;
    InValid  = iv;
    InData   = d;
    step_id++;
    sb_q.push_back('{cyc: cyc + 1, id: step_id, win: w, cnt: c, err: e, ir: ir});
  endtask

  task automatic pulse_reset();
    Enable  = 1'b1;
    Flush   = 1'b0;
    ShiftEn = 1'b0;
    InValid = 1'b0;
    step_id++;
    rst_q.push_back('{cyc: 0, id: step_id, win: 16'h0, cnt: 7'd0, err: 1'b0, ir: 1'b1});
    nReset = 1'b0;
    #4;
    nReset = 1'b1;
  endtask

  initial begin
    nReset   = 1'b1;
    Enable   = 1'b1;
    Flush    = 1'b0;
    ShiftEn  = 1'b0;
    NumShift = 5'd0;
    InValid  = 1'b0;
    InData   = 32'h0;
    #2;
    step_id++;
    rst_q.push_back('{cyc: 0, id: step_id, win: 16'h0, cnt: 7'd0, err: 1'b0, ir: 1'b1});
    nReset = 1'b0;
    #20;
    nReset = 1'b1;

    //    en    fl    se    ns     iv    data           win      cnt    err   ir
    // Fill
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'hA5A50000, 16'hA5A5, 7'd32, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h12345678, 16'hA5A5, 7'd64, 1'b0, 1'b0);
    // Shift
    step(1'b1, 1'b0, 1'b1, 5'd4,  1'b0, 32'h0,        16'h5A50, 7'd60, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd20, 1'b0, 32'h0,        16'h0012, 7'd40, 1'b0, 1'b0);
    // Enable low freezes everything
    step(1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 32'hFFFFFFFF, 16'h0012, 7'd40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 32'hFFFFFFFF, 16'h0012, 7'd40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 32'hFFFFFFFF, 16'h0012, 7'd40, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        16'h0246, 7'd35, 1'b0, 1'b0);
    // Flush
    step(1'b1, 1'b1, 1'b1, 5'd3,  1'b1, 32'hFFFFFFFF, 16'h0000, 7'd0,  1'b0, 1'b0);
    // Simultaneous shift and accept
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h11223344, 16'h1122, 7'd32, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 32'hDEADBEEF, 16'h2233, 7'd56, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd24, 1'b0, 32'h0,        16'hDEAD, 7'd32, 1'b0, 1'b1);
    // Underflow from 9 bits, error sticky through traffic, cleared by flush
    step(1'b1, 1'b0, 1'b1, 5'd23, 1'b0, 32'h0,        16'h7780, 7'd9,  1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 32'h0,        16'h0000, 7'd0,  1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'hCAFEF00D, 16'hCAFE, 7'd32, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 32'h0,        16'hF00D, 7'd16, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        16'h0000, 7'd0,  1'b0, 1'b0);
    // Refill to 64, then async reset between edges
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'hA5A50000, 16'hA5A5, 7'd32, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h12345678, 16'hA5A5, 7'd64, 1'b0, 1'b0);
    @(posedge Clk);
    #3;
    pulse_reset();
    // Fresh fill after reset, then max shift and exact-count shift
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'hA5A50000, 16'hA5A5, 7'd32, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h12345678, 16'hA5A5, 7'd64, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd4,  1'b0, 32'h0,        16'h5A50, 7'd60, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 32'h0,        16'h91A2, 7'd29, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd29, 1'b0, 32'h0,        16'h0000, 7'd0,  1'b0, 1'b1);

    @(negedge Clk);
    ShiftEn = 1'b0;
    InValid = 1'b0;
    repeat (3) @(negedge Clk);
    n_chk++;
    if (sb_q.size() != 0 || rst_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d step and %0d reset expectations left unchecked",
               sb_q.size(), rst_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_bitstream_shifter.md
# cavlc_bitstream_shifter

Bitstream front end of the CAVLC decoder. Accepts 32-bit words of the coded stream from the upstream word source through a valid/ready handshake. Keeps up to 64 unconsumed bits and presents the next 16 bits, MSB-first, to the coeff-token, level and zero decoders. Consumes bits under control of the ShiftEn/NumShift pair driven by the control FSM, and reports BarrelShifterReady back to it.

## Interface
Parameters:
- none. Word width fixed at 32, buffer at 64, window at 16.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- Enable  in  1  from FSM BarrelShiftEn; low = freeze (no shift, no fetch).
- Flush  in  1  synchronous clear of buffer, count and error.
- InData  in  32  stream word; InData[31] is the earliest bit.
- InValid  in  1  InData valid.
- InReady  out  1  word accepted on the edge where InValid && InReady.
- ShiftEn  in  1  consume NumShift bits this cycle.
- NumShift  in  5  bits to consume, 0..31.
- Window  out  16  next 16 buffered bits; Window[15] is the next bit.
- BarrelShifterReady  out  1  BitCount >= 32.
- BitCount  out  7  valid bits held, 0..64.
- ShiftError  out  1  sticky; a shift exceeded BitCount.

## Operation
State:
- Buf[63:0] is MSB-aligned: Buf[63] is the next bit. Bits below the valid count are zero.
- Cnt[6:0].
- Err.

Combinational outputs (from registers only):
- Window = Buf[63:48].
- BitCount = Cnt.
- BarrelShifterReady = (Cnt >= 32).
- ShiftError = Err.
- InReady = Enable && !Flush && (Cnt <= 32). InReady does not depend on ShiftEn or InValid.

Per cycle, when Enable=1 and Flush=0:
- Shift amount s = ShiftEn ? NumShift : 0.
- Accept acc = InValid && InReady.
- Normal case (s <= Cnt):
  - Buf' = (Buf << s), with InData OR-ed in at bits [63-(Cnt-s) -: 32] when acc.
  - Cnt' = Cnt - s + 32*acc.
- Underflow (s > Cnt):
  - Err' = 1.
  - Buf and Cnt clear to 0 before the append.
  - If acc, InData lands at Buf[63:32] and Cnt' = 32.

Other conditions:
- Enable=0: ShiftEn and InValid are ignored. Buf, Cnt and Err hold.
- Flush=1 has highest priority:
  - Buf, Cnt and Err clear next edge.
  - No word is accepted.
  - Any shift is discarded.
- Width rules:
  - Cnt never exceeds 64, guaranteed by the Cnt <= 32 accept gate.
  - Cnt - s is computed in 7 bits, with the underflow check done before the subtract.

Reset (nReset low, asynchronous):
- Buf = 0, Cnt = 0, Err = 0.
- So Window = 0x0000, BitCount = 0, BarrelShifterReady = 0, ShiftError = 0.
- InReady = Enable.
- Reset mid-stream discards all buffered bits.

## Timing
- Every shift and accept takes effect at the next rising edge. Window, BitCount and Ready reflect it in the following cycle.
- Fill latency from empty:
  - Word accepted at edge N.
  - BarrelShifterReady = 1 and Window valid from cycle N+1.
- Back-to-back:
  - A simultaneous shift and accept in one cycle is legal and is resolved as specified above.
  - A full 64-bit buffer drops InReady until Cnt <= 32.
- The FSM may shift every cycle. The decoder guarantees any code it decodes fits in Window; NumShift up to 31 is legal if Cnt allows.
- No combinational path from InValid, ShiftEn or NumShift to InReady, Ready or Window.

## Test plan
- **Fill.** Reset, Enable=1, send 0xA5A50000 then 0x12345678 with InValid held. Required:
  - Cycle after first accept: Cnt=32, Ready=1, Window=0xA5A5.
  - Next cycle: Cnt=64, InReady=0.
- **Shift.** From the 64-bit state above:
  - ShiftEn with NumShift=4 → Window=0x5A50, Cnt=60.
  - Then NumShift=20 → Window=0x0012, Cnt=40, InReady=0.
- **Simultaneous shift and accept.** Buffer holds 0x11223344 (Cnt=32). In one cycle, NumShift=8 plus accept of 0xDEADBEEF. Required:
  - Cnt=56, Window=0x2233.
  - Then NumShift=24 → Window=0xDEAD, Cnt=32.
- **Underflow.** With Cnt=9, ShiftEn with NumShift=16 and no accept. Required:
  - ShiftError=1, Cnt=0, Ready=0, Window=0x0000.
  - ShiftError stays 1 through later normal traffic.
  - Flush clears it next cycle.
- **Enable low.** Cnt=40, Enable=0, ShiftEn=1, NumShift=5, InValid=1. Required:
  - InReady=0; Window and Cnt unchanged for 3 cycles.
  - Enable=1 resumes, and the first shift consumes 5 bits.
- **Async reset mid-operation.** With Cnt=64, pulse nReset low between clock edges. Required:
  - BitCount=0, Ready=0, Window=0x0000 immediately.
  - After release, a fresh fill behaves as in the Fill test.
